// File: rtl/prng_pkg.sv
// Shared constants and Galois step helper for the LFSR random-number source.
package prng_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  localparam logic [0:0] ST_WARM = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Maximal-length feedback masks, zero-extended to MAX_WIDTH
  localparam logic [MAX_WIDTH-1:0] TAPS_W8  = 64'h0000_0000_0000_00B8;
  localparam logic [MAX_WIDTH-1:0] TAPS_W16 = 64'h0000_0000_0000_B400;
  localparam logic [MAX_WIDTH-1:0] TAPS_W32 = 64'h0000_0000_8020_0003;
  localparam logic [MAX_WIDTH-1:0] TAPS_W64 = 64'hD800_0000_0000_0000;

  function automatic logic [MAX_WIDTH-1:0] default_taps(input int unsigned width);
    case (width)
      8:       return TAPS_W8;
      16:      return TAPS_W16;
      64:      return TAPS_W64;
      default: return TAPS_W32;
    endcase
  endfunction

  // One Galois shift; callers keep bits above their width at zero
  function automatic logic [MAX_WIDTH-1:0] galois_step(input logic [MAX_WIDTH-1:0] s,
                                                       input logic [MAX_WIDTH-1:0] taps);
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

endpackage

// File: rtl/prng_step.sv
// Combinational STEPS-deep unrolled Galois LFSR advance.
module prng_step
  import prng_pkg::*;
#(
  parameter int unsigned          WIDTH = 32,
  parameter logic [MAX_WIDTH-1:0] TAPS  = TAPS_W32,
  parameter int unsigned          STEPS = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_c
);

  localparam logic [WIDTH-1:0]     TAPS_W   = TAPS[WIDTH-1:0];
  localparam logic [MAX_WIDTH-1:0] TAPS_EXT = MAX_WIDTH'(TAPS_W);

  logic [MAX_WIDTH-1:0] acc;

  always_comb begin
    acc = MAX_WIDTH'(state_i);
    for (int unsigned i = 0; i < STEPS; i++) begin
      acc = galois_step(acc, TAPS_EXT);
    end
    state_c = acc[WIDTH-1:0];
  end

endmodule

// File: rtl/prng_lfsr_gen.sv
// Galois-LFSR random word source with warm-up discard, reseed, lockup repair
// and a valid/ready output register.
module prng_lfsr_gen
  import prng_pkg::*;
#(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [MAX_WIDTH-1:0] TAPS     = default_taps(32),
  parameter logic [MAX_WIDTH-1:0] INIT     = 64'h0000_0000_AB31_2DEF,
  parameter int unsigned          STEPS    = 1,
  parameter int unsigned          WARMUP   = 6,
  parameter bit                   FREE_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] num,
  output logic             num_valid,
  input  logic             num_ready,
  output logic             busy,
  output logic             lockup_err
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [WIDTH-1:0] TAPS_W   = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_W   = INIT[WIDTH-1:0];
  localparam logic [CNT_W-1:0] WARMUP_C = CNT_W'(WARMUP);
  localparam logic [0:0]       ST_START = (WARMUP == 0) ? ST_RUN : ST_WARM;
  localparam logic             BUSY_START = (WARMUP != 0);

  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("prng_lfsr_gen: WIDTH must be 8..64");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("prng_lfsr_gen: STEPS must be 1..WIDTH");
  end
  if (WARMUP > 255) begin : g_bad_warmup
    $error("prng_lfsr_gen: WARMUP must be 0..255");
  end
  if (TAPS_W[WIDTH-1] == 1'b0) begin : g_bad_taps
    $error("prng_lfsr_gen: TAPS[WIDTH-1] must be 1");
  end
  if (INIT_W == '0) begin : g_bad_init
    $error("prng_lfsr_gen: INIT must be nonzero");
  end

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             num_valid_q, num_valid_d;
  logic             busy_q, busy_d;
  logic             lockup_err_q, lockup_err_d;

  logic [WIDTH-1:0] step_c;
  logic [WIDTH-1:0] seed_mix_c;
  logic             take_c;
  logic             slot_c;

  prng_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_step (
    .state_i (lfsr_q),
    .state_c (step_c)
  );

  // Next-state: reseed beats everything, then warm-up, lockup repair, output slot
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    num_d        = num_q;
    num_valid_d  = num_valid_q;
    busy_d       = busy_q;
    lockup_err_d = 1'b0;
    take_c       = num_valid_q & num_ready;
    slot_c       = ~num_valid_q | take_c;
    seed_mix_c   = seed_in ^ INIT_W;

    if (seed_load) begin
      lfsr_d      = (seed_mix_c == '0) ? INIT_W : seed_mix_c;
      num_valid_d = 1'b0;
      state_d     = ST_START;
      cnt_d       = WARMUP_C;
      busy_d      = BUSY_START;
    end else if (state_q == ST_WARM) begin
      lfsr_d = step_c;
      cnt_d  = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
      end
    end else if (lfsr_q == '0) begin
      // Zero is absorbing for a Galois LFSR; restart from INIT and flag it
      lfsr_d       = INIT_W;
      lockup_err_d = 1'b1;
      if (take_c) begin
        num_valid_d = 1'b0;
      end
    end else if (slot_c && enable) begin
      num_d       = lfsr_q;
      num_valid_d = 1'b1;
      lfsr_d      = step_c;
    end else if (slot_c) begin
      if (take_c) begin
        num_valid_d = 1'b0;
      end
    end else if (FREE_RUN && enable) begin
      lfsr_d = step_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_START;
      cnt_q        <= WARMUP_C;
      lfsr_q       <= INIT_W;
      num_q        <= '0;
      num_valid_q  <= 1'b0;
      busy_q       <= BUSY_START;
      lockup_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      num_q        <= num_d;
      num_valid_q  <= num_valid_d;
      busy_q       <= busy_d;
      lockup_err_q <= lockup_err_d;
    end
  end

  assign num        = num_q;
  assign num_valid  = num_valid_q;
  assign busy       = busy_q;
  assign lockup_err = lockup_err_q;

endmodule
